// File: rtl/fp_prenorm_if.sv
// ---------------------------------------------------------------------------
// fp_prenorm_if
//
// This interface groups the operand handshake and the result bus of
// fp_prenorm.
//
// Modports:
//   slave  - the fp_prenorm view. It consumes in_* and out_ready, and it
//            drives in_ready and the out_* signals.
//   master - the surrounding view, for the upstream producer and the
//            downstream consumer.
//
// Signals:
//   in_valid / in_ready / in_data[31:0]   binary32 operand handshake
//   out_valid / out_ready                 result handshake
//   out_sign, out_exp[9:0], out_mant[23:0] unpacked operand
//   out_zero, out_inf, out_nan, out_denorm class flags
// ---------------------------------------------------------------------------
interface fp_prenorm_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [9:0]  out_exp;
  logic [23:0] out_mant;
  logic        out_zero;
  logic        out_inf;
  logic        out_nan;
  logic        out_denorm;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mant,
           out_zero, out_inf, out_nan, out_denorm
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_mant,
           out_zero, out_inf, out_nan, out_denorm
  );
endinterface

// File: rtl/fp_prenorm.sv
// ---------------------------------------------------------------------------
// fp_prenorm
//
// This is the input-side pre-normalizer for binary32 operands. It unpacks
// an operand, classifies it, and normalizes denormals. The arithmetic units
// then always see a mantissa with an explicit leading 1 and a signed 10-bit
// unbiased exponent. The design is a 2-stage valid/ready pipeline.
//
// Stage 1 registers the sign, the class and the leading-zero count.
// Stage 2 applies the shift and computes the exponent.
//
// Ports:
//   clk         clock
//   rst_n       synchronous active-low reset
//   bus         fp_prenorm_if.slave (operand in, result out)
//   cnt_clr     synchronous clear of denorm_cnt (wins over increment)
//   denorm_cnt  saturating count of accepted denormal operands
//
// Build option:
//   FP_PRENORM_DAZ_EN - denormals-are-zero. A denormal produces a signed
//   zero result with out_denorm still set, and the counter still counts it.
// ---------------------------------------------------------------------------
module fp_prenorm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fp_prenorm_if.slave      bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] denorm_cnt
);

  localparam logic signed [9:0] EXP_MIN  = -10'sd126;
  localparam logic signed [9:0] EXP_BIAS = 10'sd127;
  localparam logic signed [9:0] EXP_SPEC = 10'sd128;

  // Leading zeros of a 24-bit vector. The highest set bit wins.
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Handshake: in_ready is combinational from out_ready, with no skid buffer.
  logic w_s2_adv;
  logic w_s1_adv;
  logic w_acc;

  logic [7:0]  w_e;
  logic [22:0] w_f;
  logic        w_f_nz;
  logic        w_zero;
  logic        w_inf;
  logic        w_nan;
  logic        w_den;

  logic        r_vld_p1;
  logic        r_sign_p1;
  logic [7:0]  r_e_p1;
  logic [22:0] r_f_p1;
`ifndef FP_PRENORM_DAZ_EN
  logic [4:0]  r_lzc_p1;
`endif
  logic        r_zero_p1;
  logic        r_inf_p1;
  logic        r_nan_p1;
  logic        r_den_p1;

  logic signed [9:0] w_exp_p1;
  logic [23:0]       w_mant_p1;
  logic              w_zero_p1;

  logic              r_vld_p2;
  logic              r_sign_p2;
  logic signed [9:0] r_exp_p2;
  logic [23:0]       r_mant_p2;
  logic              r_zero_p2;
  logic              r_inf_p2;
  logic              r_nan_p2;
  logic              r_den_p2;

  logic [CNT_W-1:0]  r_cnt;

  assign w_s2_adv = ~r_vld_p2 | bus.out_ready;
  assign w_s1_adv = ~r_vld_p1 | w_s2_adv;
  assign w_acc    = bus.in_valid & w_s1_adv;

  assign w_e    = bus.in_data[30:23];
  assign w_f    = bus.in_data[22:0];
  assign w_f_nz = |w_f;
  assign w_zero = (w_e == 8'd0) & ~w_f_nz;
  assign w_den  = (w_e == 8'd0) &  w_f_nz;
  assign w_inf  = (&w_e) & ~w_f_nz;
  assign w_nan  = (&w_e) &  w_f_nz;

  // ---- stage 1: accept, classify, count leading zeros ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
    end else if (w_s1_adv) begin
      r_vld_p1 <= bus.in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_sign_p1 <= bus.in_data[31];
      r_e_p1    <= w_e;
      r_f_p1    <= w_f;
`ifndef FP_PRENORM_DAZ_EN
      r_lzc_p1  <= lzc24({1'b0, w_f});
`endif
      r_zero_p1 <= w_zero;
      r_inf_p1  <= w_inf;
      r_nan_p1  <= w_nan;
      r_den_p1  <= w_den;
    end
  end

  // The counter counts at accept time, so that cnt_clr in the same cycle
  // as a denormal accept leaves the counter at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_acc & w_den) begin
      r_cnt <= sat_inc(r_cnt);
    end
  end

  always_comb begin
    w_mant_p1 = {1'b1, r_f_p1};
    w_exp_p1  = $signed({2'b00, r_e_p1}) - EXP_BIAS;
    w_zero_p1 = r_zero_p1;
    if (r_zero_p1) begin
      w_mant_p1 = '0;
      w_exp_p1  = EXP_MIN;
    end else if (r_inf_p1) begin
      w_mant_p1 = '0;
      w_exp_p1  = EXP_SPEC;
    end else if (r_nan_p1) begin
      w_exp_p1  = EXP_SPEC;
    end else if (r_den_p1) begin
`ifdef FP_PRENORM_DAZ_EN
      w_mant_p1 = '0;
      w_exp_p1  = EXP_MIN;
      w_zero_p1 = 1'b1;
`else
      // Shifting by lzc puts the leading 1 of the fraction in bit 23.
      w_mant_p1 = {1'b0, r_f_p1} << r_lzc_p1;
      w_exp_p1  = EXP_MIN - $signed({5'b00000, r_lzc_p1});
`endif
    end
  end

  // ---- stage 2: shifted mantissa and exponent, held under backpressure ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p2  <= 1'b0;
      r_sign_p2 <= 1'b0;
      r_exp_p2  <= '0;
      r_mant_p2 <= '0;
      r_zero_p2 <= 1'b0;
      r_inf_p2  <= 1'b0;
      r_nan_p2  <= 1'b0;
      r_den_p2  <= 1'b0;
    end else if (w_s2_adv) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_sign_p2 <= r_sign_p1;
        r_exp_p2  <= w_exp_p1;
        r_mant_p2 <= w_mant_p1;
        r_zero_p2 <= w_zero_p1;
        r_inf_p2  <= r_inf_p1;
        r_nan_p2  <= r_nan_p1;
        r_den_p2  <= r_den_p1;
      end
    end
  end

  assign bus.in_ready   = w_s1_adv;
  assign bus.out_valid  = r_vld_p2;
  assign bus.out_sign   = r_sign_p2;
  assign bus.out_exp    = r_exp_p2;
  assign bus.out_mant   = r_mant_p2;
  assign bus.out_zero   = r_zero_p2;
  assign bus.out_inf    = r_inf_p2;
  assign bus.out_nan    = r_nan_p2;
  assign bus.out_denorm = r_den_p2;
  assign denorm_cnt     = r_cnt;

endmodule

// File: tb/tb_fp_prenorm.sv
module tb_fp_prenorm;
  logic       clk;
  logic       rst_n;
  logic       cnt_clr;
  logic [3:0] denorm_cnt;
  int         n_tests;
  int         n_fail;

  fp_prenorm_if bus ();

  fp_prenorm #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cnt_clr    (cnt_clr),
    .denorm_cnt (denorm_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FP_PRENORM_DAZ_EN
  localparam logic [9:0]  E_DEN1 = 10'h382;
  localparam logic [23:0] M_DEN1 = 24'h000000;
  localparam logic [9:0]  E_DEN2 = 10'h382;
  localparam logic [23:0] M_DEN2 = 24'h000000;
  localparam logic [3:0]  F_DEN  = 4'b1001;
`else
  localparam logic [9:0]  E_DEN1 = 10'h36B;
  localparam logic [23:0] M_DEN1 = 24'h800000;
  localparam logic [9:0]  E_DEN2 = 10'h381;
  localparam logic [23:0] M_DEN2 = 24'h800000;
  localparam logic [3:0]  F_DEN  = 4'b0001;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // flags are packed as {zero, inf, nan, denorm}
  task automatic run_vec(input string tag, input logic [31:0] d, input logic sgn,
                         input logic [9:0] ex, input logic [23:0] mt, input logic [3:0] fl);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.out_ready = 1'b1;
    #1 chk({tag, "_inrdy"}, 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_vld"},  64'(bus.out_valid), 64'd1);
    chk({tag, "_sign"}, 64'(bus.out_sign), 64'(sgn));
    chk({tag, "_exp"},  64'(bus.out_exp), 64'(ex));
    chk({tag, "_mant"}, 64'(bus.out_mant), 64'(mt));
    chk({tag, "_flg"},  64'({bus.out_zero, bus.out_inf, bus.out_nan, bus.out_denorm}), 64'(fl));
  endtask

  logic [33:0] got_q [3];
  int          n_got;
  int          cyc;

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    cnt_clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_vld",   64'(bus.out_valid), 64'd0);
    chk("rst_mant",  64'(bus.out_mant), 64'd0);
    chk("rst_exp",   64'(bus.out_exp), 64'd0);
    chk("rst_cnt",   64'(denorm_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_inrdy", 64'(bus.in_ready), 64'd1);

    run_vec("one",    32'h3F800000, 1'b0, 10'h000, 24'h800000, 4'b0000);
    run_vec("den1",   32'h00000001, 1'b0, E_DEN1,  M_DEN1,     F_DEN);
    chk("cnt1", 64'(denorm_cnt), 64'd1);
    run_vec("den4m",  32'h00400000, 1'b0, E_DEN2,  M_DEN2,     F_DEN);
    chk("cnt2", 64'(denorm_cnt), 64'd2);
    run_vec("nzero",  32'h80000000, 1'b1, 10'h382, 24'h000000, 4'b1000);
    run_vec("pzero",  32'h00000000, 1'b0, 10'h382, 24'h000000, 4'b1000);
    run_vec("inf",    32'h7F800000, 1'b0, 10'h080, 24'h000000, 4'b0100);
    run_vec("nan",    32'h7FC00000, 1'b0, 10'h080, 24'hC00000, 4'b0010);
    run_vec("npi",    32'hC0490FDB, 1'b1, 10'h001, 24'hC90FDB, 4'b0000);
    run_vec("maxn",   32'h7F7FFFFF, 1'b0, 10'h07F, 24'hFFFFFF, 4'b0000);
    run_vec("minn",   32'h00800000, 1'b0, 10'h382, 24'h800000, 4'b0000);
    chk("cnt_norm", 64'(denorm_cnt), 64'd2);

    // Backpressure: A, B are accepted and C waits.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h3F800000;
    @(negedge clk);
    chk("bp_rdy1", 64'(bus.in_ready), 64'd1);
    bus.in_data = 32'h40000000;
    @(negedge clk);
    bus.in_data = 32'h40400000;
    #1;
    chk("bp_full", 64'(bus.in_ready), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_hold_v", 64'(bus.out_valid), 64'd1);
      chk("bp_hold_d", 64'({bus.out_exp, bus.out_mant}), 64'({10'h000, 24'h800000}));
      chk("bp_hold_r", 64'(bus.in_ready), 64'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1 chk("bp_release_rdy", 64'(bus.in_ready), 64'd1);
    n_got = 0;
    got_q[0] = {bus.out_exp, bus.out_mant};
    n_got = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 0;
    while (n_got < 3 && cyc < 10) begin
      if (bus.out_valid) begin
        got_q[n_got] = {bus.out_exp, bus.out_mant};
        n_got++;
      end
      cyc++;
      @(negedge clk);
    end
    chk("bp_count", 64'(n_got), 64'd3);
    chk("bp_res0", 64'(got_q[0]), 64'({10'h000, 24'h800000}));
    chk("bp_res1", 64'(got_q[1]), 64'({10'h001, 24'h800000}));
    chk("bp_res2", 64'(got_q[2]), 64'({10'h001, 24'hC00000}));
    chk("bp_nodup", 64'(bus.out_valid), 64'd0);

    // Reset with two operands in flight
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h00000001;
    @(negedge clk);
    bus.in_data = 32'h00000002;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("rf_cnt_pre", 64'(denorm_cnt), 64'd4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rf_vld",   64'(bus.out_valid), 64'd0);
    chk("rf_cnt",   64'(denorm_cnt), 64'd0);
    chk("rf_inrdy", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    n_got = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.out_valid) n_got++;
    end
    chk("rf_stale", 64'(n_got), 64'd0);

    // Counter saturation and clear priority
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.in_data = 32'h00000001 + 32'(k);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("cnt_sat", 64'(denorm_cnt), 64'd15);
    @(negedge clk);
    chk("cnt_hold", 64'(denorm_cnt), 64'd15);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h00000005;
    cnt_clr = 1'b1;
    #1 chk("clr_acc_rdy", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    cnt_clr = 1'b0;
    chk("cnt_clr", 64'(denorm_cnt), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h00000003;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("cnt_after_clr", 64'(denorm_cnt), 64'd1);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
